fifo_uart_tx: RTL and testbench

//   Downstream drain stage for the team's 8-bit, 32-entry FIFO. Pops one byte
//   at a time through the FIFO read port and serialises it on TX as a UART
//   8N1 frame at a fixed clocks-per-bit rate. It keeps draining while the

---
 rtl/fifo_uart_tx_if.sv | 23 ++
 rtl/fifo_uart_tx.sv | 150 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Read port between the 8-bit FIFO and its UART drain stage.
//   FIFO_EMPTY_N : 1 = FIFO holds at least one byte (FIFO -> drain)
//   FIFO_DATA    : read data, valid the cycle after FIFO_READ (FIFO -> drain)
//   FIFO_READ    : one-cycle pop request (drain -> FIFO)
interface fifo_uart_tx_if;
  logic       FIFO_EMPTY_N;
  logic [7:0] FIFO_DATA;
  logic       FIFO_READ;

  // Drain side: pops the FIFO.
  modport master (
    input  FIFO_EMPTY_N,
    input  FIFO_DATA,
    output FIFO_READ
  );

  // FIFO side: answers pop requests.
  modport slave (
    output FIFO_EMPTY_N,
    output FIFO_DATA,
    input  FIFO_READ
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as a UART 8N1 frame.
//   CLOCK, RESET_N : clock (rising edge) and async active-low reset
//   ENABLE         : 1 = start new frames; 0 = finish current frame, then idle
//   fifo           : FIFO read port (empty flag, read data, pop request)
//   TX             : serial line, idle high
//   BUSY           : high in every state except IDLE
//   BYTE_DONE      : one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  input  logic           ENABLE,
  fifo_uart_tx_if.master fifo,
  output logic           TX,
  output logic           BUSY,
  output logic           BYTE_DONE
);

  localparam int unsigned BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W    = 3;
  localparam int unsigned DATA_W   = 8;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                fifo_read_q, fifo_read_d;
  logic                busy_q, busy_d;
  logic                byte_done_q, byte_done_d;
  logic                baud_last_c;
  logic                next_frame_c;

  assign baud_last_c  = (baud_q == BAUD_LAST);
  // A new frame is only requested when enabled and the FIFO has data.
  assign next_frame_c = ENABLE && fifo.FIFO_EMPTY_N;

  // Next-state logic; outputs are decoded from the next state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = 1'b1;
    fifo_read_d = 1'b0;
    busy_d      = 1'b0;
    byte_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (next_frame_c) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Read data is valid now, one cycle after the pop.
        shift_d = fifo.FIFO_DATA;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last_c) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last_c) begin
          baud_d  = '0;
          state_d = next_frame_c ? S_REQ : S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    fifo_read_d = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE);
    byte_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
  end

  // State and output registers; reset drives the line idle immediately.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign fifo.FIFO_READ = fifo_read_q;
  assign TX             = tx_q;
  assign BUSY           = busy_q;
  assign BYTE_DONE      = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: instance A runs at 4 clocks/bit, instance B at 2 clocks/bit.
module tb_fifo_uart_tx;
  localparam int unsigned CPB_A = 4;
  localparam int unsigned CPB_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, en_b;
  logic tx_a, busy_a, bd_a;
  logic tx_b, busy_b, bd_b;

  fifo_uart_tx_if ifa();
  fifo_uart_tx_if ifb();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(en_a), .fifo(ifa.master),
    .TX(tx_a), .BUSY(busy_a), .BYTE_DONE(bd_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(en_b), .fifo(ifb.master),
    .TX(tx_b), .BUSY(busy_b), .BYTE_DONE(bd_b)
  );

  // Behavioural FIFOs: registered read data, valid the cycle after a pop.
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int rd_cnt_a = 0, bd_cnt_a = 0, rd_cnt_b = 0, bd_cnt_b = 0;

  assign ifa.FIFO_EMPTY_N = (wr_a != rd_a);
  assign ifb.FIFO_EMPTY_N = (wr_b != rd_b);

  always @(posedge clk) begin
    if (ifa.FIFO_READ) begin
      ifa.FIFO_DATA <= mem_a[rd_a % 64];
      rd_a          <= rd_a + 1;
      rd_cnt_a      <= rd_cnt_a + 1;
    end
    if (ifb.FIFO_READ) begin
      ifb.FIFO_DATA <= mem_b[rd_b % 64];
      rd_b          <= rd_b + 1;
      rd_cnt_b      <= rd_cnt_b + 1;
    end
    if (bd_a) bd_cnt_a <= bd_cnt_a + 1;
    if (bd_b) bd_cnt_b <= bd_cnt_b + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a % 64] = b;
    wr_a++;
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wr_b % 64] = b;
    wr_b++;
  endtask

  function automatic logic get_tx(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic get_bd(input int sel);
    return (sel != 0) ? bd_b : bd_a;
  endfunction

  // Wait (bounded) for the first start-bit cycle; returns cycles waited.
  task automatic wait_start(input int sel, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (get_tx(sel) !== 1'b0 && waited < 2000);
    check("start_seen", 32'(get_tx(sel)), 32'd0);
  endtask

  // Check one whole frame cycle by cycle; ends on the last stop-bit cycle.
  task automatic recv_frame(input int sel, input int cpb, input logic [7:0] exp,
                            input int drop_at, output int waited);
    logic [7:0] data;
    logic       lvl;
    int         slot;
    data = exp;
    wait_start(sel, waited);
    for (int i = 1; i <= 10 * cpb; i++) begin
      if (i > 1) @(negedge clk);
      slot = (i - 1) / cpb;
      if (slot == 0)      lvl = 1'b0;
      else if (slot == 9) lvl = 1'b1;
      else                lvl = data[slot-1];
      check($sformatf("tx_slot%0d", slot), 32'(get_tx(sel)), 32'(lvl));
      check("byte_done", 32'(get_bd(sel)), 32'(i == 10 * cpb));
      check("busy_frame", 32'(get_busy(sel)), 32'd1);
      if (i == drop_at) en_a = 1'b0;
    end
  endtask

  int w, base_rd, base_bd;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_bd_a", 32'(bd_a), 32'd0);
    check("rst_read_a", 32'(ifa.FIFO_READ), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single byte 0xA5
    base_rd = rd_cnt_a;
    en_a = 1'b1;
    push_a(8'hA5);
    recv_frame(0, CPB_A, 8'hA5, 0, w);
    @(negedge clk);
    check("t1_busy_end", 32'(busy_a), 32'd0);
    check("t1_tx_end", 32'(tx_a), 32'd1);
    check("t1_reads", 32'(rd_cnt_a - base_rd), 32'd1);

    // 2: back-to-back 0x00 then 0xFF
    base_rd = rd_cnt_a;
    push_a(8'h00);
    push_a(8'hFF);
    recv_frame(0, CPB_A, 8'h00, 0, w);
    @(negedge clk);
    check("t2_gap1_tx", 32'(tx_a), 32'd1);
    check("t2_gap1_read", 32'(ifa.FIFO_READ), 32'd1);
    @(negedge clk);
    check("t2_gap2_tx", 32'(tx_a), 32'd1);
    check("t2_gap2_read", 32'(ifa.FIFO_READ), 32'd0);
    recv_frame(0, CPB_A, 8'hFF, 0, w);
    check("t2_gap_len", 32'(w), 32'd1);
    @(negedge clk);
    check("t2_busy_end", 32'(busy_a), 32'd0);
    check("t2_reads", 32'(rd_cnt_a - base_rd), 32'd2);

    // 3: empty FIFO, enabled
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("t3_read", 32'(ifa.FIFO_READ), 32'd0);
      check("t3_tx", 32'(tx_a), 32'd1);
      check("t3_busy", 32'(busy_a), 32'd0);
    end

    // 4: ENABLE dropped during data bit 3 with two bytes queued
    base_rd = rd_cnt_a;
    base_bd = bd_cnt_a;
    push_a(8'h3C);
    push_a(8'h81);
    recv_frame(0, CPB_A, 8'h3C, 17, w);
    @(negedge clk);
    check("t4_busy_idle", 32'(busy_a), 32'd0);
    repeat (50) @(negedge clk);
    check("t4_reads_held", 32'(rd_cnt_a - base_rd), 32'd1);
    check("t4_bd_count", 32'(bd_cnt_a - base_bd), 32'd1);
    check("t4_still_idle", 32'(busy_a), 32'd0);
    en_a = 1'b1;
    recv_frame(0, CPB_A, 8'h81, 0, w);
    @(negedge clk);
    check("t4_reads", 32'(rd_cnt_a - base_rd), 32'd2);

    // 5: reset during data bit 5 of 0x5A (bit 5 = 0)
    base_rd = rd_cnt_a;
    push_a(8'h5A);
    push_a(8'h99);
    wait_start(0, w);
    repeat (25) @(negedge clk);
    check("t5_bit5", 32'(tx_a), 32'd0);
    base_bd = bd_cnt_a;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx_a), 32'd1);
    check("t5_rst_busy", 32'(busy_a), 32'd0);
    check("t5_rst_bd", 32'(bd_a), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_no_bd", 32'(bd_cnt_a - base_bd), 32'd0);
    rst_n = 1'b1;
    recv_frame(0, CPB_A, 8'h99, 0, w);
    @(negedge clk);
    check("t5_reads", 32'(rd_cnt_a - base_rd), 32'd2);
    check("t5_bd_after", 32'(bd_cnt_a - base_bd), 32'd1);

    // 6: 32 incrementing bytes at 2 clocks/bit
    for (int i = 0; i < 32; i++) push_b(8'(i));
    en_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      recv_frame(1, CPB_B, 8'(i), 0, w);
    end
    @(negedge clk);
    check("t6_busy_end", 32'(busy_b), 32'd0);
    check("t6_reads", 32'(rd_cnt_b), 32'd32);
    check("t6_bd_count", 32'(bd_cnt_b), 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
